// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared CPU definitions: opcode values, fetch FSM states,
//             default widths and the two-byte opcode decode.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_ADDR_W_DEF = 8;
    localparam int c_DATA_W_DEF = 8;

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_LDI   = 4'h1;
    localparam logic [3:0] c_OP_JMP   = 4'h5;
    localparam logic [3:0] c_OP_JZ    = 4'h6;
    localparam logic [3:0] c_OP_JC    = 4'h7;
    localparam logic [3:0] c_OP_LOAD  = 4'h8;
    localparam logic [3:0] c_OP_STORE = 4'h9;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        EXEC      = 2'd2
    } fetch_state_t;

    // Opcodes that carry a second byte (immediate, address or jump target)
    function automatic logic is_two_byte(input logic [3:0] op);
        logic r;
        case (op)
            c_OP_LDI, c_OP_JMP, c_OP_JZ, c_OP_JC, c_OP_LOAD, c_OP_STORE: r = 1'b1;
            default:                                                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pc_counter
//  Brief    : Program counter with load, increment (wrapping) and hold.
//             Load wins over increment.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc_q;
    logic [ADDR_W-1:0] w_pc_d;

    // Next pc: jump target, natural wrap-around increment, or hold
    always_comb begin
        w_pc_d = r_pc_q;
        if (i_load) begin
            w_pc_d = i_load_val;
        end else if (i_inc) begin
            w_pc_d = r_pc_q + ADDR_W'(1);
        end
    end

    // pc register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q <= '0;
        end else begin
            r_pc_q <= w_pc_d;
        end
    end

    assign o_pc = r_pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Brief    : Instruction fetch unit. Fetches a one- or two-byte instruction
//             from instruction memory, holds IR and immediate, and hands the
//             decoded fields to the control unit during a single EXEC cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              pc_en,
    input  logic              pc_load,
    input  logic              ir_load,
    output logic [3:0]        opcode,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [DATA_W-1:0] imm,
    output logic              exec,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      r_state_q;
    fetch_state_t      w_state_d;
    logic [DATA_W-1:0] r_ir_q;
    logic [DATA_W-1:0] w_ir_d;
    logic [DATA_W-1:0] r_imm_q;
    logic [DATA_W-1:0] w_imm_d;
    logic              w_pc_inc;
    logic              w_pc_load;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_pc;

    // Jump target is the low ADDR_W bits of the immediate (zero-extended if wider)
    assign w_jump_target = ADDR_W'(r_imm_q);

    // Fetch sequencing: next state, IR/immediate capture and pc control
    always_comb begin
        w_state_d = r_state_q;
        w_ir_d    = r_ir_q;
        w_imm_d   = r_imm_q;
        w_pc_inc  = 1'b0;
        w_pc_load = 1'b0;
        case (r_state_q)
            FETCH_OP: begin
                // Without ir_load the returned byte is dropped and re-requested
                if (imem_ack && ir_load) begin
                    w_ir_d    = imem_rdata;
                    w_pc_inc  = 1'b1;
                    w_state_d = is_two_byte(imem_rdata[7:4]) ? FETCH_IMM : EXEC;
                end
            end
            FETCH_IMM: begin
                if (imem_ack) begin
                    w_imm_d   = imem_rdata;
                    w_pc_inc  = 1'b1;
                    w_state_d = EXEC;
                end
            end
            EXEC: begin
                // pc already points past this instruction, so pc_en only resumes fetch
                if (pc_load) begin
                    w_pc_load = 1'b1;
                    w_state_d = FETCH_OP;
                end else if (pc_en) begin
                    w_state_d = FETCH_OP;
                end
            end
            default: begin
                w_state_d = FETCH_OP;
            end
        endcase
    end

    // State, IR and immediate registers; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= FETCH_OP;
            r_ir_q    <= DATA_W'({c_OP_NOP, 4'b0000});
            r_imm_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ir_q    <= w_ir_d;
            r_imm_q   <= w_imm_d;
        end
    end

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (w_jump_target),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    // Request and exec are gated by reset so nothing leaks out while it is held
    assign imem_req  = ~rst & (r_state_q != EXEC);
    assign exec      = ~rst & (r_state_q == EXEC);
    assign imem_addr = w_pc;
    assign pc        = w_pc;

    assign opcode = r_ir_q[7:4];
    assign rd     = r_ir_q[3:2];
    assign rs     = r_ir_q[1:0];
    assign imm    = r_imm_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter and instruction-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, instruction-byte width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  ADDR_W  fetch address, equal to pc.
REQ-007 SHALL have port imem_ack  input  1  memory response; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  DATA_W  fetched byte.
REQ-009 SHALL have port pc_en  input  1  from control unit; advance to the next instruction.
REQ-010 SHALL have port pc_load  input  1  from control unit; jump to imm.
REQ-011 SHALL have port ir_load  input  1  from control unit; permits capture of a new opcode byte.
REQ-012 SHALL have port opcode  output  4  IR[7:4]; feeds the control unit.
REQ-013 SHALL have port rd  output  2  IR[3:2], destination register index.
REQ-014 SHALL have port rs  output  2  IR[1:0], source register index.
REQ-015 SHALL have port imm  output  DATA_W  second instruction byte: immediate, address or jump target.
REQ-016 SHALL have port exec  output  1  high while in EXEC; control-unit outputs are meaningful only then.
REQ-017 SHALL have port pc  output  ADDR_W  current program counter.

Function
REQ-018 SHALL implement FSM states FETCH_OP, FETCH_IMM and EXEC.
REQ-019 In FETCH_OP or FETCH_IMM, imem_req SHALL be 1 and imem_addr SHALL equal pc; in EXEC, imem_req SHALL be 0.
REQ-020 FETCH_OP with imem_ack=1 and ir_load=1: IR<=imem_rdata and pc<=pc+1.
REQ-021 Next state from FETCH_OP: FETCH_IMM if the new opcode is two-byte (0001 LDI, 0101 JMP, 0110 JZ, 0111 JC, 1000 LOAD, 1001 STORE); otherwise EXEC.
REQ-022 FETCH_OP with imem_ack=1 and ir_load=0: IR, pc and state SHALL stay unchanged, and the byte is dropped.
REQ-023 FETCH_IMM with imem_ack=1: imm<=imem_rdata, pc<=pc+1, state<=EXEC.
REQ-024 For one-byte instructions, imm SHALL keep its previous value.
REQ-025 In either fetch state, imem_ack=0 SHALL hold state, pc and imem_addr; there is no timeout.
REQ-026 imem_ack SHALL be ignored in EXEC.
REQ-027 EXEC with pc_load=1: pc<=imm[ADDR_W-1:0] and state<=FETCH_OP; pc_load has priority over pc_en.
REQ-028 EXEC with pc_load=0 and pc_en=1: state<=FETCH_OP and pc unchanged, since it already points at the next instruction.
REQ-029 EXEC with pc_load=0 and pc_en=0: remain in EXEC (stall/halt) and hold all registers.
REQ-030 pc increment SHALL be modulo 2^ADDR_W: FF+1=00, including between the opcode byte and the operand byte.
REQ-031 Minimum latency SHALL be 2 cycles per one-byte instruction and 3 cycles per two-byte instruction with zero-wait memory.
REQ-032 The exec pulse SHALL last exactly one cycle per instruction unless stalled per REQ-029.
REQ-033 opcode, rd, rs, imm and pc SHALL be registered outputs that change only on the clk edges defined above.

Reset
REQ-034 On rst=1 at a clk edge: state<=FETCH_OP, pc<=0, IR<=8'h00 (NOP), imm<=0.
REQ-035 While rst=1, imem_req and exec SHALL be forced to 0 combinationally.
REQ-036 Reset asserted mid-fetch or mid-EXEC SHALL abandon the instruction; a same-cycle imem_ack SHALL be ignored.
REQ-037 After rst deasserts, the first request SHALL be issued to address 0 in the first cycle.

Structure
REQ-038 A shared package cpu_pkg SHALL hold the opcode constants, the FSM state enum, ADDR_W/DATA_W defaults and a two-byte-opcode decode function used here and by the control unit.
REQ-039 One sub-module, pc_counter (load/increment/hold with wrap), SHALL be instantiated; the FSM and IR stay in instr_fetch.

Verification
REQ-040 Zero-wait memory holding 00,00 at 0x00: states cycle FETCH_OP,EXEC,FETCH_OP,EXEC; pc goes 0,1,2; exec high every 2nd cycle.
REQ-041 Mem[0]=0x15, mem[1]=0xA5, 3-cycle ack delay on each byte: opcode=1, rd=1, rs=1, imm=0xA5 at EXEC; pc=2.
REQ-042 JMP (0x50, 0x40) with pc_load=1 in EXEC: next imem_addr=0x40; the pc_en=1 asserted in the same cycle is ignored.
REQ-043 pc preset via jump to 0xFF holding two-byte LDI: opcode fetched at FF, imm at 00, EXEC with pc=01.
REQ-044 rst=1 during FETCH_IMM with ack=1 that cycle: next cycle pc=0, IR=00, imem_req=1 at address 0, imm=0.
REQ-045 EXEC with pc_en=0 and pc_load=0 for 5 cycles: exec held high, imem_req=0; pc_en=1 then resumes fetch at the unchanged pc.
